control_unit: RTL

Hardwired control sequencer for the single-bus CPU datapath. It walks each instruction through fetch and a per-class execute sequence, driving one bus-source strobe and the required register-load strobes per cycle. It consumes the IR opcode and the CON flag from the datapath. It owns PC increment, memory read/write timing and halting.

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/control_unit_if.sv | 24 ++
 rtl/control_unit_decode.sv | 51 +++++
 rtl/control_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the single-bus CPU control path: opcodes, sequencer
// states and instruction classes.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = OP_ADD;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_F0     = 3'd1,
    ST_F1     = 3'd2,
    ST_F1W    = 3'd3,
    ST_F2     = 3'd4,
    ST_EXEC   = 3'd5,
    ST_HALTED = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    ALU_R, ALU_I, MULDIV, UNARY, LD, LDI, ST, BR,
    JR, JAL, IN, OUT, MFHI, MFLO, NOP, HALT
  } instr_class_e;

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath signal bundle. The control unit is the master:
// it consumes IR/CON/Stop and drives every strobe.
interface control_unit_if #(parameter int OPW = 5);
  logic [31:0]    IR;
  logic           CON, Stop, Run;
  logic           PCout, ZHIout, ZLOout, MDRout, HIout, LOout, INPORTout, Cout, Rout, BAout;
  logic           PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin, CONin, OUTPORTin;
  logic           Gra, Grb, Grc, IncPC, Read, write;
  logic [OPW-1:0] alu_op;

  modport master (
    input  IR, CON, Stop,
    output Run, PCout, ZHIout, ZLOout, MDRout, HIout, LOout, INPORTout, Cout, Rout, BAout,
           PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin, CONin, OUTPORTin,
           Gra, Grb, Grc, IncPC, Read, write, alu_op
  );

  modport slave (
    output IR, CON, Stop,
    input  Run, PCout, ZHIout, ZLOout, MDRout, HIout, LOout, INPORTout, Cout, Rout, BAout,
           PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin, CONin, OUTPORTin,
           Gra, Grb, Grc, IncPC, Read, write, alu_op
  );
endinterface

// File: rtl/control_unit_decode.sv
// Opcode to instruction-class decode, plus the index of the last execute step
// of that class. Unassigned opcodes behave as nop.
module instr_class_decode
  import cpu_pkg::*;
#(
  parameter int OPW   = 5,
  parameter int STEPW = 3
) (
  input  logic [OPW-1:0]   i_opcode,
  output instr_class_e     o_class,
  output logic [STEPW-1:0] o_last_step
);

  // Opcode grouping into execute-sequence classes
  always_comb begin
    o_class = NOP;
    case (i_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
      OP_SHL, OP_ROR, OP_ROL:          o_class = ALU_R;
      OP_ADDI, OP_ANDI, OP_ORI:        o_class = ALU_I;
      OP_MUL, OP_DIV:                  o_class = MULDIV;
      OP_NEG, OP_NOT:                  o_class = UNARY;
      OP_LD:                           o_class = LD;
      OP_LDI:                          o_class = LDI;
      OP_ST:                           o_class = ST;
      OP_BR:                           o_class = BR;
      OP_JR:                           o_class = JR;
      OP_JAL:                          o_class = JAL;
      OP_IN:                           o_class = IN;
      OP_OUT:                          o_class = OUT;
      OP_MFHI:                         o_class = MFHI;
      OP_MFLO:                         o_class = MFLO;
      OP_HALT:                         o_class = HALT;
      default:                         o_class = NOP;
    endcase
  end

  // Final execute step per class
  always_comb begin
    o_last_step = STEPW'(3'd0);
    case (o_class)
      ALU_R, ALU_I, LDI: o_last_step = STEPW'(3'd2);
      MULDIV, BR:        o_last_step = STEPW'(3'd3);
      UNARY, JAL:        o_last_step = STEPW'(3'd1);
      LD:                o_last_step = STEPW'(3'd5);
      ST:                o_last_step = STEPW'(3'd4);
      default:           o_last_step = STEPW'(3'd0);
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch, per-class execute steps and halt, with
// strobes decoded as a Moore function of state, step and opcode.
module control_unit
  import cpu_pkg::*;
#(
  parameter int OPW   = 5,
  parameter int STEPW = 3
) (
  input  logic            Clock,
  input  logic            clr,
  control_unit_if.master  bus
);

  localparam logic [2:0] S_RESET  = ST_RESET;
  localparam logic [2:0] S_F0     = ST_F0;
  localparam logic [2:0] S_F1     = ST_F1;
  localparam logic [2:0] S_F1W    = ST_F1W;
  localparam logic [2:0] S_F2     = ST_F2;
  localparam logic [2:0] S_EXEC   = ST_EXEC;
  localparam logic [2:0] S_HALTED = ST_HALTED;

  localparam logic [STEPW-1:0] E0 = STEPW'(3'd0);
  localparam logic [STEPW-1:0] E1 = STEPW'(3'd1);
  localparam logic [STEPW-1:0] E2 = STEPW'(3'd2);
  localparam logic [STEPW-1:0] E3 = STEPW'(3'd3);
  localparam logic [STEPW-1:0] E4 = STEPW'(3'd4);
  localparam logic [STEPW-1:0] E5 = STEPW'(3'd5);

  logic [2:0]       r_state, w_next_state, w_end_state;
  logic [STEPW-1:0] r_step, w_next_step, w_last_step;
  logic [OPW-1:0]   w_op;
  instr_class_e     w_class;
  logic             w_unused_ir;

  assign w_op        = bus.IR[31 -: OPW];
  assign w_unused_ir = ^bus.IR[31-OPW:0];

  instr_class_decode #(.OPW(OPW), .STEPW(STEPW)) u_decode (
    .i_opcode    (w_op),
    .o_class     (w_class),
    .o_last_step (w_last_step)
  );

  // State and step registers; clr forces RESET from any state
  always_ff @(posedge Clock) begin
    if (clr) begin
      r_state <= S_RESET;
      r_step  <= E0;
    end else begin
      r_state <= w_next_state;
      r_step  <= w_next_step;
    end
  end

  // Sequencing; Stop is only looked at on an instruction's final cycle
  always_comb begin
    w_next_state = r_state;
    w_next_step  = r_step;
    w_end_state  = bus.Stop ? S_HALTED : S_F0;
    case (r_state)
      S_RESET: w_next_state = S_F0;
      S_F0:    w_next_state = S_F1;
      S_F1:    w_next_state = S_F1W;
      S_F1W:   w_next_state = S_F2;
      S_F2: begin
        w_next_step = E0;
        if (w_class == HALT) begin
          w_next_state = S_HALTED;
        end else if (w_class == NOP) begin
          w_next_state = w_end_state;
        end else begin
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_step == w_last_step) begin
          w_next_state = w_end_state;
          w_next_step  = E0;
        end else begin
          w_next_step  = r_step + E1;
        end
      end
      S_HALTED: w_next_state = S_HALTED;
      default:  w_next_state = S_RESET;
    endcase
  end

  // Strobe decode
  always_comb begin
    bus.Run = 1'b0;       bus.alu_op = {OPW{1'b0}};
    bus.PCout = 1'b0;     bus.ZHIout = 1'b0;   bus.ZLOout = 1'b0;   bus.MDRout = 1'b0;
    bus.HIout = 1'b0;     bus.LOout = 1'b0;    bus.INPORTout = 1'b0; bus.Cout = 1'b0;
    bus.Rout = 1'b0;      bus.BAout = 1'b0;    bus.PCin = 1'b0;     bus.MARin = 1'b0;
    bus.MDRin = 1'b0;     bus.IRin = 1'b0;     bus.Yin = 1'b0;      bus.Zin = 1'b0;
    bus.HIin = 1'b0;      bus.LOin = 1'b0;     bus.Rin = 1'b0;      bus.CONin = 1'b0;
    bus.OUTPORTin = 1'b0; bus.Gra = 1'b0;      bus.Grb = 1'b0;      bus.Grc = 1'b0;
    bus.IncPC = 1'b0;     bus.Read = 1'b0;     bus.write = 1'b0;
    if (r_state != S_RESET && r_state != S_HALTED) begin
      bus.Run    = 1'b1;
      bus.alu_op = w_op;
    end else begin
      bus.Run    = 1'b0;
    end
    case (r_state)
      S_F0:  begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1; end
      S_F1:  begin bus.ZLOout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; end
      S_F1W: begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
      S_F2:  begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
      S_EXEC: begin
        case (w_class)
          ALU_R, ALU_I: begin
            case (r_step)
              E0: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
              E1: begin
                bus.Zin = 1'b1;
                if (w_class == ALU_R) begin
                  bus.Grc = 1'b1; bus.Rout = 1'b1;
                end else begin
                  bus.Cout = 1'b1;
                end
              end
              E2:      begin bus.ZLOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
              default: bus.Rin = 1'b0;
            endcase
          end
          MULDIV: begin
            case (r_step)
              E0:      begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
              E1:      begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; end
              E2:      begin bus.ZLOout = 1'b1; bus.LOin = 1'b1; end
              E3:      begin bus.ZHIout = 1'b1; bus.HIin = 1'b1; end
              default: bus.HIin = 1'b0;
            endcase
          end
          UNARY: begin
            case (r_step)
              E0:      begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; end
              E1:      begin bus.ZLOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
              default: bus.Rin = 1'b0;
            endcase
          end
          // ld/ldi/st share the base+offset address computation in E0..E2
          LD, LDI, ST: begin
            case (r_step)
              E0: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
              E1: begin bus.Cout = 1'b1; bus.alu_op = ALU_ADD; bus.Zin = 1'b1; end
              E2: begin
                bus.ZLOout = 1'b1;
                if (w_class == LDI) begin
                  bus.Gra = 1'b1; bus.Rin = 1'b1;
                end else begin
                  bus.MARin = 1'b1;
                end
              end
              E3: begin
                if (w_class == ST) begin
                  bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
                end else begin
                  bus.Read = 1'b1;
                end
              end
              E4: begin
                if (w_class == ST) begin
                  bus.write = 1'b1;
                end else begin
                  bus.Read = 1'b1; bus.MDRin = 1'b1;
                end
              end
              E5:      begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
              default: bus.Rin = 1'b0;
            endcase
          end
          BR: begin
            case (r_step)
              E0: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
              E1: begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
              E2: begin bus.Cout = 1'b1; bus.alu_op = ALU_ADD; bus.Zin = 1'b1; end
              E3: begin
                if (bus.CON) begin
                  bus.ZLOout = 1'b1; bus.PCin = 1'b1;
                end else begin
                  bus.PCin = 1'b0;
                end
              end
              default: bus.PCin = 1'b0;
            endcase
          end
          JR:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
          JAL: begin
            if (r_step == E0) begin
              bus.PCout = 1'b1; bus.Grb = 1'b1; bus.Rin = 1'b1;
            end else begin
              bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
            end
          end
          IN:      begin bus.INPORTout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          OUT:     begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OUTPORTin = 1'b1; end
          MFHI:    begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          MFLO:    begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          default: bus.Rin = 1'b0;
        endcase
      end
      default: bus.IncPC = 1'b0;
    endcase
  end

endmodule
